// File: rtl/piece_drop_controller_pkg.sv
// Shared colour codes, controller state encoding and palette sequencing
// for the falling-piece controller.
package piece_drop_controller_pkg;

    typedef logic [3:0] color_t;

    localparam color_t COLOR_BLACK  = 4'd0;
    localparam color_t COLOR_LBLUE  = 4'd1;
    localparam color_t COLOR_BLUE   = 4'd2;
    localparam color_t COLOR_ORANGE = 4'd3;
    localparam color_t COLOR_YELLOW = 4'd4;
    localparam color_t COLOR_GREEN  = 4'd5;
    localparam color_t COLOR_PURPLE = 4'd6;
    localparam color_t COLOR_RED    = 4'd7;
    localparam color_t COLOR_GREY   = 4'd8;
    localparam color_t COLOR_WHITE  = 4'd9;

    typedef enum logic [1:0] {SPAWN, FALL, LOCK, OVER} ctrl_state_t;

    // Tetromino palette order; RED and any non-piece code restart at LBLUE.
    function automatic color_t next_piece_color(input color_t c);
        color_t n;
        case (c)
            COLOR_LBLUE:  n = COLOR_BLUE;
            COLOR_BLUE:   n = COLOR_ORANGE;
            COLOR_ORANGE: n = COLOR_YELLOW;
            COLOR_YELLOW: n = COLOR_GREEN;
            COLOR_GREEN:  n = COLOR_PURPLE;
            COLOR_PURPLE: n = COLOR_RED;
            default:      n = COLOR_LBLUE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/piece_drop_controller_tick_divider.sv
// Free-running modulo-DIV counter with synchronous clear; tick_o is high
// for the single cycle the count sits at DIV-1.
module tick_divider #(
    parameter int unsigned DIV = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == CW'(DIV - 1));

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/piece_drop_controller.sv
// Falling-piece sequencer: gravity, moves, hard drop, stacking, respawn.
//   state | meaning
//   SPAWN | place piece at spawn cell, test for a full spawn column
//   FALL  | accept moves/drop, step down on gravity tick
//   LOCK  | commit piece to stack height, advance colour
//   OVER  | frozen until reset
module piece_drop_controller
    import piece_drop_controller_pkg::*;
#(
    parameter int unsigned WELL_X    = 120,
    parameter int unsigned WELL_Y    = 36,
    parameter int unsigned CELL_LOG2 = 4,
    parameter int unsigned COLS      = 10,
    parameter int unsigned ROWS      = 20,
    parameter int unsigned SPAWN_COL = 4,
    parameter int unsigned TICK_DIV  = 25_000_000
) (
    input  logic        CLOCK_50,
    input  logic        reset_L,
    input  logic        move_left,
    input  logic        move_right,
    input  logic        drop,
    output logic [10:0] x_pos,
    output logic [10:0] y_pos,
    output color_t      piece_color,
    output logic        lock_pulse,
    output logic        game_over
);

    localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned HGT_W = $clog2(ROWS + 1);

    ctrl_state_t      state_q, state_d;
    logic [COL_W-1:0] col_q, col_d, move_col;
    logic [ROW_W-1:0] row_q, row_d;
    logic [HGT_W-1:0] height_q [COLS];
    logic [HGT_W-1:0] height_d [COLS];
    color_t           color_q, color_d;
    logic             left_prev_q, right_prev_q, drop_prev_q;
    logic             lock_pulse_q, game_over_q;
    logic [10:0]      x_q, y_q;

    logic             tick;
    logic             left_req, right_req, drop_req;
    logic             left_ok, right_ok;
    logic [HGT_W-1:0] row_ext, free_l, free_r, free_mv;

    function automatic logic [HGT_W-1:0] free_rows(input logic [HGT_W-1:0] h);
        return HGT_W'(ROWS) - h;
    endfunction

    function automatic logic [10:0] pixel_x(input logic [COL_W-1:0] c);
        return 11'(WELL_X) + (11'(c) << CELL_LOG2);
    endfunction

    function automatic logic [10:0] pixel_y(input logic [ROW_W-1:0] r);
        return 11'(WELL_Y) + (11'(r) << CELL_LOG2);
    endfunction

    tick_divider #(.DIV(TICK_DIV)) u_tick (
        .clk_i  (CLOCK_50),
        .rst_ni (reset_L),
        .clr_i  (state_q == SPAWN),
        .tick_o (tick)
    );

    assign left_req  = move_left  & ~left_prev_q;
    assign right_req = move_right & ~right_prev_q;
    assign drop_req  = drop       & ~drop_prev_q;

    // Wall cases force zero free rows so the move test fails without wrapping.
    assign row_ext  = HGT_W'(row_q);
    assign free_l   = (col_q != '0) ? free_rows(height_q[col_q - COL_W'(1)]) : '0;
    assign free_r   = (col_q != COL_W'(COLS - 1)) ? free_rows(height_q[col_q + COL_W'(1)]) : '0;
    assign left_ok  = left_req & ~right_req & (row_ext < free_l);
    assign right_ok = right_req & ~left_req & (row_ext < free_r);
    assign move_col = left_ok  ? col_q - COL_W'(1) :
                      right_ok ? col_q + COL_W'(1) : col_q;
    assign free_mv  = free_rows(height_q[move_col]);

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        color_d  = color_q;
        height_d = height_q;
        case (state_q)
            SPAWN: begin
                col_d   = COL_W'(SPAWN_COL);
                row_d   = '0;
                state_d = (height_q[COL_W'(SPAWN_COL)] == HGT_W'(ROWS)) ? OVER : FALL;
            end
            FALL: begin
                col_d = move_col;
                if (drop_req) begin
                    row_d   = ROW_W'(free_mv - HGT_W'(1));
                    state_d = LOCK;
                end else if (tick) begin
                    if (row_ext + HGT_W'(1) < free_mv) begin
                        row_d = row_q + ROW_W'(1);
                    end else begin
                        state_d = LOCK;
                    end
                end
            end
            LOCK: begin
                height_d[col_q] = height_q[col_q] + HGT_W'(1);
                color_d         = next_piece_color(color_q);
                col_d           = COL_W'(SPAWN_COL);
                row_d           = '0;
                state_d         = SPAWN;
            end
            default: begin
                state_d = OVER;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset_L) begin
            state_q      <= SPAWN;
            col_q        <= COL_W'(SPAWN_COL);
            row_q        <= '0;
            height_q     <= '{default: '0};
            color_q      <= COLOR_LBLUE;
            left_prev_q  <= 1'b0;
            right_prev_q <= 1'b0;
            drop_prev_q  <= 1'b0;
            lock_pulse_q <= 1'b0;
            game_over_q  <= 1'b0;
            x_q          <= pixel_x(COL_W'(SPAWN_COL));
            y_q          <= 11'(WELL_Y);
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            row_q        <= row_d;
            height_q     <= height_d;
            color_q      <= color_d;
            left_prev_q  <= move_left;
            right_prev_q <= move_right;
            drop_prev_q  <= drop;
            lock_pulse_q <= (state_d == LOCK);
            game_over_q  <= (state_d == OVER);
            x_q          <= pixel_x(col_q);
            y_q          <= pixel_y(row_q);
        end
    end

    assign x_pos       = x_q;
    assign y_pos       = y_q;
    assign piece_color = color_q;
    assign lock_pulse  = lock_pulse_q;
    assign game_over   = game_over_q;

endmodule
